// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR read/write capture paths: legal configuration
// ranges, beat ordering inside an SDR word, and the read capture FSM states.
package ddr_pkg;

  localparam int BURST_MIN = 2;
  localparam int BURST_MAX = 8;
  localparam int CL_MIN    = 1;
  localparam int CL_MAX    = 15;

  // Even (rising-edge) beat occupies the low half of a packed word.
  localparam bit EVEN_BEAT_LOW = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } cap_state_e;

  function automatic int half_burst(input int burst);
    int b;
    b = burst;
    if (b < BURST_MIN) begin
      b = BURST_MIN;
    end else if (b > BURST_MAX) begin
      b = BURST_MAX;
    end else begin
      b = burst;
    end
    return b / 2;
  endfunction

  function automatic int clamp_cl(input int cl);
    int c;
    if (cl < CL_MIN) begin
      c = CL_MIN;
    end else if (cl > CL_MAX) begin
      c = CL_MAX;
    end else begin
      c = cl;
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr_lat_pipe.sv
// Fixed-latency 1-bit shift register with synchronous reset; 'any' flags
// that at least one token is still travelling through the pipe.
module ddr_lat_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic any
);

  logic [DEPTH-1:0] sr_r;

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage delay.
      always_ff @(posedge clock) begin
        if (reset) begin
          sr_r <= 1'b0;
        end else begin
          sr_r <= din;
        end
      end
    end else begin : g_multi
      // Shift tokens toward the MSB, one stage per clock.
      always_ff @(posedge clock) begin
        if (reset) begin
          sr_r <= '0;
        end else begin
          sr_r <= {sr_r[DEPTH-2:0], din};
        end
      end
    end
  endgenerate

  assign q   = sr_r[DEPTH-1];
  assign any = |sr_r;

endmodule

// File: rtl/ddr_rd_capture.sv
// Rebuilds SDRAM read bursts from IDDR rise/fall samples into SDR words.
// Optional half-cycle realignment is enabled by DDR_RD_CAPTURE_REALIGN_EN.
module ddr_rd_capture
  import ddr_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CL_CYCLES = 3,
  parameter int BURST     = 4
) (
  input  logic               clock,
  input  logic               reset,
`ifdef DDR_RD_CAPTURE_REALIGN_EN
  input  logic               phase,
`endif
  input  logic               rd_cmd,
  input  logic [WIDTH-1:0]   d_rise,
  input  logic [WIDTH-1:0]   d_fall,
  output logic [2*WIDTH-1:0] data_out,
  output logic               data_valid,
  output logic               data_last,
  output logic               busy,
  output logic               overrun
);

  localparam int         HALF      = half_burst(BURST);
  localparam int         PIPE_D    = clamp_cl(CL_CYCLES);
  localparam logic [2:0] LAST_BEAT = 3'(HALF - 1);

  cap_state_e         state_r;
  logic [2:0]         cnt_r;
  logic [2:0]         space_r;
  logic [2*WIDTH-1:0] data_r;
  logic               valid_r;
  logic               last_r;
  logic               busy_r;
  logic               overrun_r;

  logic               accept_s;
  logic               exit_s;
  logic               pipe_any_s;
  logic               start_s;
  logic               pending_s;
  logic               sample_s;
  logic               last_s;
  logic [2:0]         cur_cnt_s;
  logic [2*WIDTH-1:0] word_s;

  // Command acceptance: enforce minimum spacing of one burst window.
  always_comb begin
    accept_s = 1'b0;
    if (!reset && rd_cmd && (space_r == 3'd0)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  ddr_lat_pipe #(
    .DEPTH (PIPE_D)
  ) u_lat_pipe (
    .clock (clock),
    .reset (reset),
    .din   (accept_s),
    .q     (exit_s),
    .any   (pipe_any_s)
  );

`ifdef DDR_RD_CAPTURE_REALIGN_EN
  logic               exit_d_r;
  logic [WIDTH-1:0]   fall_prev_r;

  // Delayed window start and previous falling beat for the shifted phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      exit_d_r    <= 1'b0;
      fall_prev_r <= '0;
    end else begin
      exit_d_r    <= exit_s;
      fall_prev_r <= d_fall;
    end
  end

  // Select window start and word packing by DQ phase.
  always_comb begin
    start_s   = exit_s;
    word_s    = {d_fall, d_rise};
    pending_s = pipe_any_s | exit_d_r;
    if (phase) begin
      start_s = exit_d_r;
      word_s  = {d_rise, fall_prev_r};
    end else begin
      start_s = exit_s;
      word_s  = EVEN_BEAT_LOW ? {d_fall, d_rise} : {d_rise, d_fall};
    end
  end
`else
  // Window opens as the command leaves the latency pipe.
  always_comb begin
    start_s   = exit_s;
    pending_s = pipe_any_s;
    word_s    = EVEN_BEAT_LOW ? {d_fall, d_rise} : {d_rise, d_fall};
  end
`endif

  // Decide whether this edge samples a beat pair and which beat index it is.
  always_comb begin
    sample_s  = 1'b0;
    cur_cnt_s = 3'd0;
    last_s    = 1'b0;
    case (state_r)
      ST_CAPTURE: begin
        sample_s  = 1'b1;
        cur_cnt_s = cnt_r;
      end
      ST_IDLE: begin
        sample_s  = start_s;
        cur_cnt_s = 3'd0;
      end
      default: begin
        sample_s  = 1'b0;
        cur_cnt_s = 3'd0;
      end
    endcase
    if (sample_s && (cur_cnt_s == LAST_BEAT)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Capture FSM and registered data strobes; state reflects beats still owed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      data_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s && (LAST_BEAT != 3'd0)) begin
            state_r <= ST_CAPTURE;
            cnt_r   <= 3'd1;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
          end
        end
        ST_CAPTURE: begin
          if (cnt_r == LAST_BEAT) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
          end else begin
            state_r <= ST_CAPTURE;
            cnt_r   <= cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
      if (sample_s) begin
        data_r <= word_s;
      end else begin
        data_r <= data_r;
      end
      valid_r <= sample_s;
      last_r  <= last_s;
    end
  end

  // Spacing counter, overrun pulse and busy flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      space_r   <= 3'd0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        space_r <= LAST_BEAT;
      end else if (space_r != 3'd0) begin
        space_r <= space_r - 3'd1;
      end else begin
        space_r <= space_r;
      end
      overrun_r <= rd_cmd & ~accept_s;
      busy_r    <= accept_s | pending_s | sample_s;
    end
  end

  assign data_out   = data_r;
  assign data_valid = valid_r;
  assign data_last  = last_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule

// File: doc/ddr_rd_capture.md
# ddr_rd_capture

Receive-side companion to the DDR output register path: takes the rising- and falling-edge samples produced by the input DDR flip-flops on the SDRAM DQ pins and rebuilds read bursts as SDR words for the memory controller's read datapath. It tracks each issued read command through a fixed CAS-latency pipeline. It opens a capture window of BURST/2 clocks and presents one 2×WIDTH word per clock, with valid, last and error strobes. It sits between the IFDDR pad registers and the controller's read FIFO.

## Interface
Parameters:
- WIDTH, 16: DQ bus width per edge.
- CL_CYCLES, 3: clocks from accepted rd_cmd to the first edge at which beat data is sampled; range 1..15.
- BURST, 4: beats per read burst; even, range 2..8.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_cmd  in  1  read command issued to SDRAM this cycle.
- d_rise  in  WIDTH  beat captured on rising edge (even beat).
- d_fall  in  WIDTH  beat captured on falling edge (odd beat).
- data_out  out  2*WIDTH  {odd beat, even beat}; even beat in the low half.
- data_valid  out  1  data_out holds a burst word.
- data_last  out  1  final word of a burst; only with data_valid.
- busy  out  1  any command in flight or window open.
- overrun  out  1  one-cycle pulse: rd_cmd rejected.

## Operation
- Accept rule: rd_cmd is accepted only if at least BURST/2 clocks have elapsed since the previous accepted rd_cmd. A spacing counter loads BURST/2-1 on accept and decrements to 0.
- Rejected rd_cmd: overrun pulses in the next cycle, and the command is dropped. Pipeline state is unaffected.
- Accepted commands enter a CL_CYCLES-deep latency shift register. Several commands may be in flight at once.
- FSM, two states:
  - IDLE: no window open. Goes to CAPTURE when a command exits the latency pipe.
  - CAPTURE: beat counter runs 0..BURST/2-1. Each clock registers {d_fall, d_rise} into data_out and asserts data_valid. data_last is asserted when count = BURST/2-1.
  - At the end of the window, go back to IDLE, or restart the count at 0 if another command exits the pipe in the same cycle. Back-to-back bursts are seamless, with no gap.
- data_out holds its last value when data_valid is low.
- busy = pipe non-zero OR state is CAPTURE OR an accepted rd_cmd is being registered.

## Timing
- rd_cmd is accepted at edge k. d_rise/d_fall are sampled at edges k+CL_CYCLES .. k+CL_CYCLES+BURST/2-1.
- data_valid is high for the BURST/2 cycles following those edges. Output latency is one register stage from the pad sample.
- data_last goes high in the same cycle as the last valid word.
- Reset, sampled high at any edge, including mid-burst:
  - clears the latency pipe, beat counter, spacing counter and FSM (to IDLE);
  - sets data_out, data_valid, data_last, busy and overrun to 0 from that edge onward;
  - drops the remainder of any partial burst; no data_last is issued for it.
- rd_cmd in the same cycle as reset is ignored.
- Spacing is exactly BURST/2: accepted, seamless.
- Spacing is BURST/2-1: rejected, overrun pulses.

## Configuration
- DDR_RD_CAPTURE_REALIGN_EN defined:
  - adds input port `phase` (1 bit, quasi-static);
  - with phase=1, words are formed as {d_rise(t), d_fall(t-1)} through an extra WIDTH register holding the previous d_fall;
  - the capture window starts one clock later than normal;
  - this compensates for a half-cycle DQ shift.
- DDR_RD_CAPTURE_REALIGN_EN undefined: no `phase` port, no extra register, and behaviour is always the phase=0 case above.

## Structure
- Shared package ddr_pkg:
  - beat-order convention (even beat low);
  - BURST/CL legal-range constants;
  - capture FSM state enum {ST_IDLE, ST_CAPTURE}.
- Sub-module ddr_lat_pipe: parameterised CL-deep 1-bit shift register with synchronous reset and `any` output. It is instantiated once here, and is reusable by the write-path DQS timing.

## Test plan
Defaults WIDTH=16, CL_CYCLES=3, BURST=4:
- Single read at edge 10, d_rise=16'h1111/16'h3333, d_fall=16'h2222/16'h4444 at edges 13/14 → data_out 32'h2222_1111 then 32'h4444_3333, valid in cycles after edges 13 and 14, data_last on the second.
- rd_cmd at edges 10 and 12 → four consecutive valid words, with data_last on words 2 and 4, no gap, no overrun.
- rd_cmd at edges 10 and 11 → second command rejected, overrun high for one cycle after edge 11, only two valid words.
- Reset asserted at edge 14 mid-burst → data_valid=0 and data_out=0 from edge 14, no data_last, busy=0; a new rd_cmd at edge 16 yields a normal burst at edges 19/20.
- rd_cmd coincident with reset → no data_valid ever produced, overrun stays 0.
- With DDR_RD_CAPTURE_REALIGN_EN and phase=1, read at edge 10 → first word {d_rise@14, d_fall@13}, valid after edges 14 and 15.
